// File: rtl/uart_pkg.sv
// UART receiver shared types: FSM state encoding, parity mode codes, parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CLEANUP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;

    // Widest supported data field; narrower frames are zero-extended.
    localparam int MAX_DATA_BITS = 9;

    // Parity bit a well-formed frame carries for the given data and mode.
    // Zero-extension leaves the result unchanged.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input int                       mode);
        logic p;
        case (mode)
            PARITY_ODD:  p = ~(^data);
            PARITY_EVEN: p = ^data;
            default:     p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchroniser: 2-FF metastability filter plus optional 3-sample majority vote.
// Latency: 2 cycles pin to o_rx_s; o_rx_smp is centred 1 cycle earlier when voting is on.
// Backpressure: none, free-running.
//
// Ports: i_Clock, i_Reset (async, active high), i_RX_Serial (raw pin),
//        o_rx_s (synchronised bit, edge detection), o_rx_smp (bit used at sample points).
// Macro UART_RX_MAJORITY_EN: o_rx_smp = majority of the current and two previous rx_s values.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_RX_Serial,
    output logic o_rx_s,
    output logic o_rx_smp
);

    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_RX_Serial};
    end

    // Reset to the idle-high line level so reset release cannot look like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Two past values plus the current one form the 3-deep window.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], sync_q[1]};
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign o_rx_smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_q[1]) | (hist_q[0] & sync_q[1]);
`else
    assign o_rx_smp = sync_q[1];
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (DATA_BITS 5..9, none/odd/even parity, 1 or 2 stop bits).
// Latency: o_RX_DV rises 1 cycle after the last stop-bit centre sample (+2 cycles pin sync).
// Backpressure: none; consumer must take o_RX_Byte on the one-cycle o_RX_DV strobe.
//
// Ports: i_Clock, i_Reset (async, active high), i_RX_Serial (raw pin, idle high),
//        o_RX_DV (frame-done strobe), o_RX_Byte (last frame's data, LSB first on the line),
//        o_Parity_Err / o_Frame_Err (valid with o_RX_DV only), o_Busy (FSM not idle).
// Macro UART_RX_MAJORITY_EN: sample points use a 3-sample majority vote (see uart_rx_sync).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    logic rx_s;
    logic rx_smp;

    uart_rx_sync u_sync (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_RX_Serial (i_RX_Serial),
        .o_rx_s      (rx_s),
        .o_rx_smp    (rx_smp)
    );

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]   shadow_q, shadow_d;
    logic                   pe_lat_q, pe_lat_d;
    logic                   fe_lat_q, fe_lat_d;
    logic                   dv_q, dv_d;
    logic [DATA_BITS-1:0]   byte_q, byte_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;

    logic                     bit_end;
    logic                     fe_now;
    logic [MAX_DATA_BITS-1:0] shadow_ext;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shadow_d   = shadow_q;
        pe_lat_d   = pe_lat_q;
        fe_lat_d   = fe_lat_q;
        byte_d     = byte_q;
        dv_d       = 1'b0;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        bit_end    = (cnt_q == CNT_END);
        fe_now     = fe_lat_q | ~rx_smp;
        shadow_ext = '0;
        shadow_ext[DATA_BITS-1:0] = shadow_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                idx_d      = '0;
                stop_idx_d = 1'b0;
                pe_lat_d   = 1'b0;
                fe_lat_d   = 1'b0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            // Re-check at mid start bit; a high line here was a glitch.
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx_smp ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d           = '0;
                    shadow_d[idx_q] = rx_smp;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    pe_lat_d = (rx_smp != parity_calc(shadow_ext, PARITY_MODE));
                    state_d  = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Result is registered on the last stop centre, no trailing half-bit,
            // so the next start edge can follow the stop bit directly.
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    fe_lat_d = fe_now;
                    if (stop_idx_q == STOP_LAST) begin
                        byte_d    = shadow_q;
                        dv_d      = 1'b1;
                        par_err_d = pe_lat_q;
                        frm_err_d = fe_now;
                        state_d   = ST_CLEANUP;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // frm_err_q is live in this cycle; after a framing error wait for a
            // high line so a break is not decoded as a new start bit.
            ST_CLEANUP: begin
                state_d = frm_err_q ? ST_WAIT_IDLE : ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shadow_q   <= '0;
            pe_lat_q   <= 1'b0;
            fe_lat_q   <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shadow_q   <= shadow_d;
            pe_lat_q   <= pe_lat_d;
            fe_lat_q   <= fe_lat_d;
            dv_q       <= dv_d;
            byte_q     <= byte_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign o_RX_DV      = dv_q;
    assign o_RX_Byte    = byte_q;
    assign o_Parity_Err = par_err_q;
    assign o_Frame_Err  = frm_err_q;
    assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three configurations driven by a frame-level line model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;

    always #5 clk = ~clk;

    // DUT 0: 8N1, DUT 1: 8 data even parity 1 stop, DUT 2: 7 data odd parity 2 stop.
    logic       a_dv, a_pe, a_fe, a_busy;
    logic [7:0] a_byte;
    logic       b_dv, b_pe, b_fe, b_busy;
    logic [7:0] b_byte;
    logic       c_dv, c_pe, c_fe, c_busy;
    logic [6:0] c_byte;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx0), .o_RX_DV(a_dv), .o_RX_Byte(a_byte),
        .o_Parity_Err(a_pe), .o_Frame_Err(a_fe), .o_Busy(a_busy));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx1), .o_RX_DV(b_dv), .o_RX_Byte(b_byte),
        .o_Parity_Err(b_pe), .o_Frame_Err(b_fe), .o_Busy(b_busy));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_c (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx2), .o_RX_DV(c_dv), .o_RX_Byte(c_byte),
        .o_Parity_Err(c_pe), .o_Frame_Err(c_fe), .o_Busy(c_busy));

    function automatic int cfg_nbits(input int d);
        return (d == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_pmode(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction
    function automatic int cfg_nstop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic got_frame(input int d, input logic [8:0] data, input logic pe, input logic fe);
        exp_t e;
        check_val($sformatf("dut%0d_strobe_expected", d), 32'(qsize(d) != 0), 32'd1);
        if (qsize(d) != 0) begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check_val($sformatf("dut%0d_data", d),   32'(data), 32'(e.data));
            check_val($sformatf("dut%0d_par_err", d), 32'(pe),  32'(e.pe));
            check_val($sformatf("dut%0d_frm_err", d), 32'(fe),  32'(e.fe));
        end
    endtask

    // Strobe monitors: every strobe must match the next expected frame; flags quiet otherwise.
    always @(negedge clk) begin
        if (a_dv === 1'b1) got_frame(0, {1'b0, a_byte}, a_pe, a_fe);
        else check_val("dut0_flags_quiet", 32'({a_pe, a_fe}), 32'd0);
        if (b_dv === 1'b1) got_frame(1, {1'b0, b_byte}, b_pe, b_fe);
        else check_val("dut1_flags_quiet", 32'({b_pe, b_fe}), 32'd0);
        if (c_dv === 1'b1) got_frame(2, {2'b0, c_byte}, c_pe, c_fe);
        else check_val("dut2_flags_quiet", 32'({c_pe, c_fe}), 32'd0);
    end

    task automatic set_line(input int d, input logic v);
        case (d)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic send_bit(input int d, input logic v);
        set_line(d, v);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int d, input int n);
        set_line(d, 1'b1);
        repeat (n * CPB) @(negedge clk);
    endtask

    // Drive one frame. bad_stop: index of a stop bit forced low (-1 none).
    // abort_bit: stop half way through that data bit (no frame expected).
    // glitch_bit: one-cycle inversion in the middle of that data bit.
    task automatic send_frame(input int d, input logic [8:0] data, input bit bad_par,
                              input int bad_stop, input int abort_bit, input int glitch_bit);
        int         nb;
        int         pm;
        int         ones;
        logic [8:0] dm;
        logic       par;
        exp_t       e;
        nb = cfg_nbits(d);
        pm = cfg_pmode(d);
        dm = '0;
        for (int i = 0; i < nb; i++) dm[i] = data[i];
        ones = $countones(dm);
        // Even mode: total ones incl. parity even; odd mode: total odd.
        par = (pm == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        if (bad_par) par = ~par;
        if (abort_bit < 0) begin
            e.data = dm;
            e.pe   = (pm != 0) && bad_par;
            e.fe   = (bad_stop >= 0);
            push_exp(d, e);
        end
        send_bit(d, 1'b0);
        for (int i = 0; i < nb; i++) begin
            if (i == abort_bit) begin
                set_line(d, dm[i]);
                repeat (CPB / 2) @(negedge clk);
                return;
            end
            if (i == glitch_bit) begin
                set_line(d, dm[i]);
                repeat (CPB / 2) @(negedge clk);
                set_line(d, ~dm[i]);
                @(negedge clk);
                set_line(d, dm[i]);
                repeat (CPB / 2 - 1) @(negedge clk);
            end else begin
                send_bit(d, dm[i]);
            end
        end
        if (pm != 0) send_bit(d, par);
        for (int s = 0; s < cfg_nstop(d); s++) send_bit(d, (s != bad_stop));
    endtask

    task automatic wait_drain(input int d);
        for (int i = 0; i < CPB * 40 && qsize(d) != 0; i++) @(negedge clk);
        check_val($sformatf("dut%0d_all_frames_seen", d), 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_dv",   32'(a_dv),   32'd0);
        check_val("rst_byte", 32'(a_byte), 32'd0);
        check_val("rst_busy", 32'({a_busy, b_busy, c_busy}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic 8N1 frame; byte holds and FSM idles afterwards.
        send_frame(0, 9'h0A5, 1'b0, -1, -1, -1);
        idle_bits(0, 1);
        wait_drain(0);
        repeat (4) @(negedge clk);
        check_val("a5_busy_after", 32'(a_busy), 32'd0);
        check_val("a5_byte_hold",  32'(a_byte), 32'hA5);

        // Even parity: 0x03 with parity 1 is wrong, with parity 0 is right.
        send_frame(1, 9'h003, 1'b1, -1, -1, -1);
        idle_bits(1, 1);
        send_frame(1, 9'h003, 1'b0, -1, -1, -1);
        idle_bits(1, 1);
        wait_drain(1);

        // Framing error followed by a held-low line: one strobe, then parked.
        send_frame(0, 9'h05A, 1'b0, 0, -1, -1);
        set_line(0, 1'b0);
        repeat (40) @(negedge clk);
        check_val("fe_strobe_done", 32'(qsize(0)), 32'd0);
        check_val("fe_wait_busy",   32'(a_busy),   32'd1);
        idle_bits(0, 2);
        check_val("fe_released",    32'(a_busy),   32'd0);
        send_frame(0, 9'h011, 1'b0, -1, -1, -1);
        idle_bits(0, 1);
        wait_drain(0);

        // Short low pulse: START entered, aborted at the centre check.
        set_line(0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("glitch_start_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (30) @(negedge clk);
        check_val("glitch_start_idle", 32'(a_busy), 32'd0);

        // Reset in the middle of data bit 3 of 0xFF: async clear, no strobe.
        send_frame(0, 9'h0FF, 1'b0, -1, 3, -1);
        check_val("pre_rst_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(a_busy), 32'd0);
        check_val("mid_rst_byte", 32'(a_byte), 32'd0);
        check_val("mid_rst_dv",   32'({a_dv, a_pe, a_fe}), 32'd0);
        set_line(0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(0, 9'h03C, 1'b0, -1, -1, -1);
        idle_bits(0, 1);
        wait_drain(0);

        // 7 data bits, 2 stop bits, back-to-back frames.
        send_frame(2, 9'h055, 1'b0, -1, -1, -1);
        send_frame(2, 9'h02A, 1'b0, -1, -1, -1);
        idle_bits(2, 1);
        wait_drain(2);
        check_val("b2b_busy_after", 32'(c_busy), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        send_frame(2, 9'h055, 1'b0, -1, -1, 2);
        send_frame(2, 9'h02A, 1'b0, -1, -1, 5);
        idle_bits(2, 1);
        wait_drain(2);
`endif

        // Randomized frames with occasional parity and stop-bit corruption.
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 10; k++) begin
                logic [8:0] rd;
                bit         bp;
                int         bs;
                rd = 9'($urandom);
                bp = (cfg_pmode(d) != 0) && ($urandom_range(0, 3) == 0);
                bs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, cfg_nstop(d) - 1)) : -1;
                send_frame(d, rd, bp, bs, -1, -1);
                idle_bits(d, (bs >= 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2)));
            end
            idle_bits(d, 1);
            wait_drain(d);
        end
        repeat (4) @(negedge clk);
        check_val("final_busy", 32'({a_busy, b_busy, c_busy}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- Per-frame parity and framing error flags, an input synchroniser, and a guard against false starts after a framing error.
- Sits between the board RX pin and byte-level consumers (command decoder, FIFO); one frame in, one one-cycle valid strobe out.

Parameters:
- CLKS_PER_BIT, 868, i_Clock cycles per bit (clock freq / baud); legal range >= 8.
- DATA_BITS, 8, data bits per frame, LSB first; legal 5..9.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits expected; legal 1 or 2.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_RX_Serial  in  1  raw serial line, idle high, asynchronous to i_Clock
- o_RX_DV  out  1  one-cycle strobe: frame complete
- o_RX_Byte  out  DATA_BITS  received data; holds last frame until next o_RX_DV
- o_Parity_Err  out  1  parity mismatch; valid only in the o_RX_DV cycle, else 0
- o_Frame_Err  out  1  a stop bit sampled low; valid only in the o_RX_DV cycle, else 0
- o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: async on i_Reset high.
  - All outputs 0, state IDLE, counters 0.
  - Synchroniser flops reset to 1 (idle line).
  - Reset mid-frame abandons the frame; no strobe is issued.
- Input: 2-FF synchroniser; all decisions use the synchronised bit rx_s. Pin-to-FSM latency is 2 cycles.
- Clock counter width: $clog2(CLKS_PER_BIT); no fixed 8-bit counter. Bit index width: $clog2(DATA_BITS).
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_IDLE.
- IDLE:
  - Counter = 0, index = 0.
  - rx_s == 0 -> START.
- START:
  - Count to (CLKS_PER_BIT-1)/2, then sample.
  - Sample 0 -> clear counter, go to DATA.
  - Sample 1 -> treat as glitch, return to IDLE; no strobe, no flags.
- DATA:
  - Sample at counter == CLKS_PER_BIT-1 (bit centre); write into o_RX_Byte shadow [index].
  - After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Sample at centre.
  - Error when XOR(data, sampled bit) is 0 (odd mode) or 1 (even mode).
- STOP:
  - Sample each of STOP_BITS stop bits at centre; any 0 sets the frame-error latch.
  - On the final stop-bit sample, with no extra half-bit wait, register:
    - o_RX_Byte <= shadow
    - o_RX_DV <= 1
    - error flags <= latches
  - Then -> CLEANUP.
- CLEANUP:
  - One cycle; o_RX_DV and flags return to 0.
  - -> WAIT_IDLE if a frame error occurred, else -> IDLE.
- WAIT_IDLE: stay until rx_s == 1, then -> IDLE. This prevents a break or held-low line from being decoded as a fresh start bit.
- Strobe timing: o_RX_DV rises 1 cycle after the final stop-bit centre sample, so back-to-back frames are accepted with zero idle gap.
- o_RX_Byte updates only with o_RX_DV; a parity- or frame-errored byte is still presented, with its flag set.
- DATA_BITS == 9: o_RX_Byte is 9 bits wide, and bit 8 is included in parity.
- Default parameters (8, none, 1) are cycle-identical to the current receiver, except for the 2-cycle synchroniser delay and the WAIT_IDLE state.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: keep a 3-deep history of rx_s. Every sample point (start check, data, parity, stop) uses the majority of the 3 most recent values, which rejects single-cycle glitches. The sample window is centred 1 cycle early; no other timing change.
- Undefined: single-sample rx_s at each sample point; history register absent.

Decomposition:
- Package uart_pkg:
  - state enum (rx_state_t)
  - PARITY_NONE / PARITY_ODD / PARITY_EVEN localparams
  - function parity_calc(data, mode)
- Sub-module uart_rx_sync:
  - 2-FF synchroniser plus optional 3-sample majority history.
  - Output: one clean bit; reset value 1.

Test Plan (CLKS_PER_BIT=16 unless noted):
- 8N1, send 0xA5 -> exactly one o_RX_DV pulse, o_RX_Byte=0xA5, both error flags 0, o_Busy low after CLEANUP.
- PARITY_MODE=2, send 0x03 with parity bit 1 -> o_RX_DV with o_Parity_Err=1, o_RX_Byte=0x03. Repeat with parity bit 0 -> flag 0.
- Send 0x5A with stop bit 0, then hold line low 40 cycles -> one strobe with o_Frame_Err=1, FSM held in WAIT_IDLE, no second strobe. Release line, send 0x11 -> received cleanly.
- Low pulse of 5 cycles on idle line -> START aborts at centre check, no o_RX_DV, o_Busy returns to 0.
- i_Reset asserted during data bit 3 of 0xFF -> outputs 0 immediately (async). Deassert, send 0x3C -> o_RX_Byte=0x3C, no stale bits.
- DATA_BITS=7, STOP_BITS=2: send 0x55, 0x2A back-to-back with no idle gap -> two strobes, bytes 0x55 then 0x2A. With UART_RX_MAJORITY_EN, a 1-cycle glitch at a data-bit centre leaves the byte uncorrupted.
